// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: the WIDTH-bit add is cut into STAGES equal slices, one per
// register stage, with the carry rippling stage to stage. The whole pipe stalls as a unit.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: STAGES must lie in 1..WIDTH and divide WIDTH");
    end

    localparam int unsigned S = WIDTH / STAGES;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // SUB is a + ~b + 1; cin only matters for ADD.
    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // IW: operand bits not yet consumed on entry to this stage; RW: result bits done here.
        localparam int unsigned IW = WIDTH - k * S;
        localparam int unsigned RW = (k + 1) * S;

        logic          src_valid;
        logic          src_c;
        logic [IW-1:0] src_a;
        logic [IW-1:0] src_b;
        logic [S:0]    slice_sum;
        logic [RW-1:0] r_d;

        logic          valid_q;
        logic          carry_q;
        logic [RW-1:0] r_q;

        if (k == 0) begin : g_src
            assign src_valid = in_valid;
            assign src_c     = c0;
            assign src_a     = a;
            assign src_b     = b_eff;
            assign r_d       = slice_sum[S-1:0];
        end else begin : g_src
            assign src_valid = g_stage[k-1].valid_q;
            assign src_c     = g_stage[k-1].carry_q;
            assign src_a     = g_stage[k-1].g_fwd.a_q;
            assign src_b     = g_stage[k-1].g_fwd.b_q;
            assign r_d       = {slice_sum[S-1:0], g_stage[k-1].r_q};
        end

        assign slice_sum = {1'b0, src_a[S-1:0]} + {1'b0, src_b[S-1:0]} + {{S{1'b0}}, src_c};

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                r_q     <= '0;
            end else if (advance) begin
                valid_q <= src_valid;
                carry_q <= slice_sum[S];
                r_q     <= r_d;
            end
        end

        // Upper operand slices travel alongside the partial result until consumed.
        if (k < STAGES - 1) begin : g_fwd
            logic [IW-S-1:0] a_q;
            logic [IW-S-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= src_a[IW-1:S];
                    b_q <= src_b[IW-1:S];
                end
            end
        end
    end

    logic ovf_d;
    logic zero_d;
    logic ovf_q;
    logic zero_q;

    // The last stage still holds the operand MSBs, so the flags are formed beside the final sum.
    assign ovf_d  = (g_stage[STAGES-1].src_a[S-1] == g_stage[STAGES-1].src_b[S-1]) &&
                    (g_stage[STAGES-1].r_d[WIDTH-1] != g_stage[STAGES-1].src_a[S-1]);
    assign zero_d = ~|g_stage[STAGES-1].r_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign o         = g_stage[STAGES-1].r_q;
    assign cout      = g_stage[STAGES-1].carry_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
